// File: rtl/rv32i_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_pkg
// Shared encodings and stage-bundle types for the RV32I control pipeline.
//   RESULT_ALU / RESULT_MEM : result-source select (resultSrc)
//   fwd_sel_e               : forwarding select for the EX-stage operands
//   ex_ctrl_t / mem_ctrl_t / wb_ctrl_t : control bundles held in the
//                             ID/EX, EX/MEM and MEM/WB registers. Each stage
//                             keeps only the fields it or a later stage uses.
// Optional feature macro used by the importing modules: FORWARD_EN.
// ---------------------------------------------------------------------------
package rv32i_pkg;

  localparam int REG_ADDR_WIDTH = 5;
  localparam int ALU_CTRL_WIDTH = 3;

  localparam logic RESULT_ALU = 1'b0;
  localparam logic RESULT_MEM = 1'b1;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic                      reg_write;
    logic                      mem_write;
    logic                      result_src;
    logic                      branch;
    logic                      alu_src;
    logic [ALU_CTRL_WIDTH-1:0] alu_control;
    logic [REG_ADDR_WIDTH-1:0] rd;
  } ex_ctrl_t;

  typedef struct packed {
    logic                      reg_write;
    logic                      mem_write;
    logic                      result_src;
    logic [REG_ADDR_WIDTH-1:0] rd;
  } mem_ctrl_t;

  typedef struct packed {
    logic                      reg_write;
    logic                      result_src;
    logic [REG_ADDR_WIDTH-1:0] rd;
  } wb_ctrl_t;

endpackage

// File: rtl/hazard_unit.sv
// ---------------------------------------------------------------------------
// hazard_unit
// Purely combinational branch resolution, RAW-hazard stall, flush and
// (optionally) operand-forwarding select.
// Ports:
//   rs1D, rs2D            source registers of the instruction in D
//   branchE, zeroE        branch control and ALU zero flag of the E instruction
//   regWriteE, rdE        destination of the E instruction
//   regWriteM, rdM        destination of the M instruction
//   resultSrcE            E instruction is a load          (FORWARD_EN only)
//   rs1E, rs2E            sources of the E instruction     (FORWARD_EN only)
//   regWriteW, rdW        destination of the W instruction (FORWARD_EN only)
//   forwardAE, forwardBE  forwarding selects, fwd_sel_e    (FORWARD_EN only)
//   pcSrcE                take the branch target
//   stallF, stallD        hold PC / IF/ID
//   flushD, flushE        clear IF/ID / load a bubble into ID/EX
// Macro FORWARD_EN: forwarding from M/W; only load-use stalls. Without it,
// any dependence on an E or M producer stalls.
// ---------------------------------------------------------------------------
module hazard_unit
  import rv32i_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_WIDTH
) (
  input  logic [REG_ADDR_W-1:0] rs1D,
  input  logic [REG_ADDR_W-1:0] rs2D,
  input  logic                  branchE,
  input  logic                  zeroE,
  input  logic                  regWriteE,
  input  logic [REG_ADDR_W-1:0] rdE,
  input  logic                  regWriteM,
  input  logic [REG_ADDR_W-1:0] rdM,
`ifdef FORWARD_EN
  input  logic                  resultSrcE,
  input  logic [REG_ADDR_W-1:0] rs1E,
  input  logic [REG_ADDR_W-1:0] rs2E,
  input  logic                  regWriteW,
  input  logic [REG_ADDR_W-1:0] rdW,
  output logic [1:0]            forwardAE,
  output logic [1:0]            forwardBE,
`endif
  output logic                  pcSrcE,
  output logic                  stallF,
  output logic                  stallD,
  output logic                  flushD,
  output logic                  flushE
);

  // x0 is hard-wired to zero, so a write to it never creates a dependence.
  function automatic logic writes_src(input logic                  wr,
                                      input logic [REG_ADDR_W-1:0] rd,
                                      input logic [REG_ADDR_W-1:0] a,
                                      input logic [REG_ADDR_W-1:0] b);
    return wr && (rd != '0) && ((rd == a) || (rd == b));
  endfunction

  logic raw_stall;

`ifdef FORWARD_EN
  // M holds the younger result, so it takes priority over W.
  function automatic fwd_sel_e fwd_sel(input logic [REG_ADDR_W-1:0] rs);
    if (regWriteM && (rdM != '0) && (rdM == rs)) return FWD_MEM;
    if (regWriteW && (rdW != '0) && (rdW == rs)) return FWD_WB;
    return FWD_NONE;
  endfunction

  assign forwardAE = fwd_sel(rs1E);
  assign forwardBE = fwd_sel(rs2E);

  // A load's data is not available until after M, so only load-use stalls.
  assign raw_stall = (resultSrcE == RESULT_MEM) &&
                     writes_src(regWriteE, rdE, rs1D, rs2D);
`else
  // No bypass paths: wait until the producer has reached W (write-first RF).
  assign raw_stall = writes_src(regWriteE, rdE, rs1D, rs2D) ||
                     writes_src(regWriteM, rdM, rs1D, rs2D);
`endif

  // A taken branch kills the D instruction, so stalling it would be pointless.
  assign pcSrcE = branchE & zeroE;
  assign stallF = raw_stall & ~pcSrcE;
  assign stallD = raw_stall & ~pcSrcE;
  assign flushD = pcSrcE;
  assign flushE = raw_stall | pcSrcE;

endmodule

// File: rtl/ctrl_pipeline.sv
// ---------------------------------------------------------------------------
// ctrl_pipeline
// Carries decoded controls and register addresses through ID/EX, EX/MEM and
// MEM/WB; resolves branches in E and drives IF/ID stall/flush via hazard_unit.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   regWriteD..aluControlD         decode-stage controls
//   rs1D, rs2D, rdD                register addresses of the D instruction
//   zeroE                          ALU zero flag of the E instruction
//   aluSrcE, aluControlE           EX-stage controls
//   memWriteM                      MEM-stage write enable
//   regWriteW, resultSrcW, rdW     WB-stage controls
//   pcSrcE, stallF, stallD, flushD branch redirect and IF/ID control
//   forwardAE, forwardBE           forwarding selects (FORWARD_EN only)
// Macro FORWARD_EN enables the forwarding outputs and load-use-only stalls.
// ---------------------------------------------------------------------------
module ctrl_pipeline
  import rv32i_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_WIDTH,
  parameter int ALU_CTRL_W = ALU_CTRL_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  regWriteD,
  input  logic                  memWriteD,
  input  logic                  resultSrcD,
  input  logic                  branchD,
  input  logic                  aluSrcD,
  input  logic [ALU_CTRL_W-1:0] aluControlD,
  input  logic [REG_ADDR_W-1:0] rs1D,
  input  logic [REG_ADDR_W-1:0] rs2D,
  input  logic [REG_ADDR_W-1:0] rdD,
  input  logic                  zeroE,
  output logic                  aluSrcE,
  output logic [ALU_CTRL_W-1:0] aluControlE,
  output logic                  memWriteM,
  output logic                  regWriteW,
  output logic                  resultSrcW,
  output logic [REG_ADDR_W-1:0] rdW,
  output logic                  pcSrcE,
`ifdef FORWARD_EN
  output logic [1:0]            forwardAE,
  output logic [1:0]            forwardBE,
`endif
  output logic                  stallF,
  output logic                  stallD,
  output logic                  flushD
);

  ex_ctrl_t  ex_d, ex_q;
  mem_ctrl_t mem_q;
  wb_ctrl_t  wb_q;
  logic      flush_e;

  // NOTE: every field gets a default first, so no path through this block
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    ex_d = '0;
    if (!flush_e) begin
      ex_d.reg_write   = regWriteD;
      ex_d.mem_write   = memWriteD;
      ex_d.result_src  = resultSrcD;
      ex_d.branch      = branchD;
      ex_d.alu_src     = aluSrcD;
      ex_d.alu_control = aluControlD;
      ex_d.rd          = rdD;
    end
  end

  // NOTE: non-blocking assignments let every stage sample the previous
  // stage's old value on the same edge, which is what makes this a pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q             <= ex_d;
      mem_q.reg_write  <= ex_q.reg_write;
      mem_q.mem_write  <= ex_q.mem_write;
      mem_q.result_src <= ex_q.result_src;
      mem_q.rd         <= ex_q.rd;
      wb_q.reg_write   <= mem_q.reg_write;
      wb_q.result_src  <= mem_q.result_src;
      wb_q.rd          <= mem_q.rd;
    end
  end

`ifdef FORWARD_EN
  // Source addresses are only needed in E when bypass muxes exist.
  logic [REG_ADDR_W-1:0] rs1_e_q, rs2_e_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs1_e_q <= '0;
      rs2_e_q <= '0;
    end else if (flush_e) begin
      rs1_e_q <= '0;
      rs2_e_q <= '0;
    end else begin
      rs1_e_q <= rs1D;
      rs2_e_q <= rs2D;
    end
  end
`endif

  hazard_unit #(.REG_ADDR_W(REG_ADDR_W)) u_hazard (
    .rs1D      (rs1D),
    .rs2D      (rs2D),
    .branchE   (ex_q.branch),
    .zeroE     (zeroE),
    .regWriteE (ex_q.reg_write),
    .rdE       (ex_q.rd),
    .regWriteM (mem_q.reg_write),
    .rdM       (mem_q.rd),
`ifdef FORWARD_EN
    .resultSrcE(ex_q.result_src),
    .rs1E      (rs1_e_q),
    .rs2E      (rs2_e_q),
    .regWriteW (wb_q.reg_write),
    .rdW       (wb_q.rd),
    .forwardAE (forwardAE),
    .forwardBE (forwardBE),
`endif
    .pcSrcE    (pcSrcE),
    .stallF    (stallF),
    .stallD    (stallD),
    .flushD    (flushD),
    .flushE    (flush_e)
  );

  assign aluSrcE     = ex_q.alu_src;
  assign aluControlE = ex_q.alu_control;
  assign memWriteM   = mem_q.mem_write;
  assign regWriteW   = wb_q.reg_write;
  assign resultSrcW  = wb_q.result_src;
  assign rdW         = wb_q.rd;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// ---------------------------------------------------------------------------
// tb_ctrl_pipeline
// Randomised and directed stimulus for ctrl_pipeline. The driver tracks which
// instruction occupies E, M and W, derives the expected outputs of every
// cycle from the hazard/forwarding rules and queues them; a monitor compares
// each cycle's outputs on the falling edge. Build with +define+FORWARD_EN to
// exercise the forwarding variant.
// ---------------------------------------------------------------------------
module tb_ctrl_pipeline;
  import rv32i_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       regWriteD, memWriteD, resultSrcD, branchD, aluSrcD;
  logic [2:0] aluControlD;
  logic [4:0] rs1D, rs2D, rdD;
  logic       zeroE;
  logic       aluSrcE, memWriteM, regWriteW, resultSrcW, pcSrcE;
  logic       stallF, stallD, flushD;
  logic [2:0] aluControlE;
  logic [4:0] rdW;
  logic [1:0] fwd_a, fwd_b;

  always #5 clk = ~clk;

  ctrl_pipeline dut (
    .clk(clk), .rst(rst),
    .regWriteD(regWriteD), .memWriteD(memWriteD), .resultSrcD(resultSrcD),
    .branchD(branchD), .aluSrcD(aluSrcD), .aluControlD(aluControlD),
    .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD), .zeroE(zeroE),
    .aluSrcE(aluSrcE), .aluControlE(aluControlE), .memWriteM(memWriteM),
    .regWriteW(regWriteW), .resultSrcW(resultSrcW), .rdW(rdW),
    .pcSrcE(pcSrcE),
`ifdef FORWARD_EN
    .forwardAE(fwd_a), .forwardBE(fwd_b),
`endif
    .stallF(stallF), .stallD(stallD), .flushD(flushD)
  );

`ifndef FORWARD_EN
  assign fwd_a = 2'b00;
  assign fwd_b = 2'b00;
`endif

  typedef struct packed {
    logic       rw, mw, ld, br, asrc;
    logic [2:0] alu;
    logic [4:0] rs1, rs2, rd;
  } instr_t;

  typedef struct packed {
    logic       alu_src;
    logic [2:0] alu_ctrl;
    logic       mem_write_m, reg_write_w, result_src_w;
    logic [4:0] rd_w;
    logic       pc_src, stall_f, stall_d, flush_d;
    logic [1:0] fwd_a, fwd_b;
  } exp_t;

  exp_t   exp_q[$];
  int     total = 0;
  int     bad   = 0;

  // Instruction currently occupying each stage (all-zero = bubble).
  instr_t in_e, in_m, in_w;
  instr_t cur_d;
  exp_t   last_exp;
  logic   last_flush_e;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  function automatic logic needs(input instr_t p, input instr_t d);
    return p.rw && p.rd != 5'd0 && (p.rd == d.rs1 || p.rd == d.rs2);
  endfunction

  function automatic logic [1:0] fwd_for(input logic [4:0] rs);
    if (in_m.rw && in_m.rd != 5'd0 && in_m.rd == rs) return 2'b10;
    if (in_w.rw && in_w.rd != 5'd0 && in_w.rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic predict(input instr_t d, input logic z, output exp_t e,
                         output logic fe);
    logic raw, taken;
    taken = in_e.br & z;
`ifdef FORWARD_EN
    raw = in_e.ld & needs(in_e, d);
`else
    raw = needs(in_e, d) | needs(in_m, d);
`endif
    e = '0;
    e.alu_src      = in_e.asrc;
    e.alu_ctrl     = in_e.alu;
    e.mem_write_m  = in_m.mw;
    e.reg_write_w  = in_w.rw;
    e.result_src_w = in_w.ld;
    e.rd_w         = in_w.rd;
    e.pc_src       = taken;
    e.stall_f      = raw & ~taken;
    e.stall_d      = raw & ~taken;
    e.flush_d      = taken;
`ifdef FORWARD_EN
    e.fwd_a        = fwd_for(in_e.rs1);
    e.fwd_b        = fwd_for(in_e.rs2);
`endif
    fe = raw | taken;
  endtask

  // IF/ID behaviour: a stall holds the D instruction, a flush empties it.
  function automatic instr_t next_d(input instr_t proposed);
    if (last_exp.stall_d) return cur_d;
    if (last_exp.flush_d) return '0;
    return proposed;
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    i.rw   = ($urandom % 4) != 0;
    i.ld   = i.rw && ($urandom % 3) == 0;
    i.mw   = !i.rw && ($urandom % 2) == 0;
    i.br   = ($urandom % 5) == 0;
    i.asrc = $urandom % 2;
    i.alu  = 3'($urandom);
    i.rs1  = 5'($urandom_range(0, 5));
    i.rs2  = 5'($urandom_range(0, 5));
    i.rd   = 5'($urandom_range(0, 5));
    return i;
  endfunction

  // One clock: advance the stage model across the edge, then present the
  // new D instruction / zero flag and queue the outputs expected this cycle.
  task automatic cycle(input instr_t d, input logic z, input logic do_rst);
    @(posedge clk);
    if (rst) begin
      in_e = '0; in_m = '0; in_w = '0;
    end else begin
      in_w = in_m;
      in_m = in_e;
      in_e = last_flush_e ? instr_t'('0) : cur_d;
    end
    #1;
    rst = do_rst;
    if (do_rst) begin
      in_e = '0; in_m = '0; in_w = '0;
    end
    cur_d       = d;
    regWriteD   = d.rw;  memWriteD = d.mw; resultSrcD = d.ld;
    branchD     = d.br;  aluSrcD   = d.asrc; aluControlD = d.alu;
    rs1D        = d.rs1; rs2D      = d.rs2;  rdD         = d.rd;
    zeroE       = z;
    predict(d, z, last_exp, last_flush_e);
    exp_q.push_back(last_exp);
  endtask

  function automatic logic [31:0] all_outs();
    return {12'd0, aluSrcE, aluControlE, memWriteM, regWriteW, resultSrcW,
            rdW, pcSrcE, stallF, stallD, flushD, fwd_a, fwd_b};
  endfunction

  // Monitor: one expected record per cycle, compared mid-cycle.
  int mon_cycle = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        mon_cycle++;
        check($sformatf("cycle%0d_outputs", mon_cycle), all_outs(), {12'd0, e});
      end
    end
  end

  instr_t bub, i_pass, i_lw, i_dep, i_br, i_x, i_bl, i_a, i_b, i_c, i_p, i_q;

  initial begin
    bub = '0;
    in_e = '0; in_m = '0; in_w = '0; cur_d = '0;
    last_exp = '0; last_flush_e = 1'b0;
    rst = 1'b1;
    regWriteD = 1'b1; memWriteD = 1'b0; resultSrcD = 1'b1; branchD = 1'b1;
    aluSrcD = 1'b1; aluControlD = 3'b111; rs1D = 5'd1; rs2D = 5'd2; rdD = 5'd3;
    zeroE = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("reset_outputs_zero", all_outs(), 32'd0);

    // Bubbles after reset release.
    repeat (4) cycle(bub, 1'b0, 1'b0);
    #2 check("bubbles_regWriteW", {31'd0, regWriteW}, 32'd0);

    // Pass-through.
    i_pass = '0; i_pass.rw = 1'b1; i_pass.rd = 5'd7; i_pass.alu = 3'b010;
    cycle(i_pass, 1'b0, 1'b0);
    cycle(bub, 1'b0, 1'b0);
    #2 check("pass_aluControlE", {29'd0, aluControlE}, 32'd2);
    cycle(bub, 1'b0, 1'b0);
    cycle(bub, 1'b0, 1'b0);
    #2 check("pass_regWriteW", {31'd0, regWriteW}, 32'd1);
    check("pass_rdW", {27'd0, rdW}, 32'd7);

    // Load-use.
    i_lw  = '0; i_lw.rw = 1'b1; i_lw.ld = 1'b1; i_lw.rd = 5'd5;
    i_dep = '0; i_dep.rw = 1'b1; i_dep.rs1 = 5'd5; i_dep.rd = 5'd6; i_dep.alu = 3'b001;
    cycle(i_lw, 1'b0, 1'b0);
    cycle(i_dep, 1'b0, 1'b0);
    #2 check("lu_stallF", {31'd0, stallF}, 32'd1);
    check("lu_stallD", {31'd0, stallD}, 32'd1);
    cycle(next_d(bub), 1'b0, 1'b0);
    #2 check("lu_e_bubble", {29'd0, aluControlE}, 32'd0);
`ifdef FORWARD_EN
    check("lu_single_stall", {31'd0, stallD}, 32'd0);
    cycle(next_d(bub), 1'b0, 1'b0);
    #2 check("lu_fwdA_wb", {30'd0, fwd_a}, 32'(FWD_WB));
`else
    check("lu_second_stall", {31'd0, stallD}, 32'd1);
    cycle(next_d(bub), 1'b0, 1'b0);
    cycle(next_d(bub), 1'b0, 1'b0);
`endif
    repeat (3) cycle(next_d(bub), 1'b0, 1'b0);

    // Branch taken / not taken.
    i_br = '0; i_br.br = 1'b1; i_br.alu = 3'b110; i_br.rs1 = 5'd1; i_br.rs2 = 5'd2;
    i_x  = '0; i_x.rw = 1'b1; i_x.rd = 5'd9; i_x.alu = 3'b011;
    cycle(i_br, 1'b0, 1'b0);
    cycle(i_x, 1'b1, 1'b0);
    #2 check("br_pcSrcE", {31'd0, pcSrcE}, 32'd1);
    check("br_flushD", {31'd0, flushD}, 32'd1);
    cycle(next_d(i_x), 1'b0, 1'b0);
    #2 check("br_e_bubble", {29'd0, aluControlE}, 32'd0);
    cycle(i_br, 1'b0, 1'b0);
    cycle(i_x, 1'b0, 1'b0);
    #2 check("br_nt_pcSrcE", {30'd0, pcSrcE, flushD}, 32'd0);
    repeat (3) cycle(next_d(bub), 1'b0, 1'b0);

    // Taken branch coinciding with load-use.
    i_bl = '0; i_bl.br = 1'b1; i_bl.rw = 1'b1; i_bl.ld = 1'b1; i_bl.rd = 5'd5;
    cycle(i_bl, 1'b0, 1'b0);
    cycle(i_dep, 1'b1, 1'b0);
    #2 check("brlu_stallF", {31'd0, stallF}, 32'd0);
    check("brlu_flushD", {31'd0, flushD}, 32'd1);
    cycle(next_d(i_dep), 1'b0, 1'b0);
    #2 check("brlu_e_bubble", {29'd0, aluControlE}, 32'd0);
    repeat (3) cycle(next_d(bub), 1'b0, 1'b0);

`ifdef FORWARD_EN
    // M has priority over W.
    i_a = '0; i_a.rw = 1'b1; i_a.rd = 5'd3;
    i_b = i_a;
    i_c = '0; i_c.rs1 = 5'd3; i_c.alu = 3'b100;
    cycle(i_a, 1'b0, 1'b0);
    cycle(i_b, 1'b0, 1'b0);
    cycle(i_c, 1'b0, 1'b0);
    cycle(next_d(bub), 1'b0, 1'b0);
    #2 check("prio_fwdA_mem", {30'd0, fwd_a}, 32'(FWD_MEM));
`else
    // ALU producer without bypass stalls its consumer for two cycles.
    i_p = '0; i_p.rw = 1'b1; i_p.rd = 5'd4;
    i_q = '0; i_q.rs2 = 5'd4; i_q.alu = 3'b101;
    cycle(i_p, 1'b0, 1'b0);
    cycle(i_q, 1'b0, 1'b0);
    #2 check("alu_stall_1", {31'd0, stallD}, 32'd1);
    cycle(next_d(bub), 1'b0, 1'b0);
    #2 check("alu_stall_2", {31'd0, stallD}, 32'd1);
    cycle(next_d(bub), 1'b0, 1'b0);
    #2 check("alu_stall_done", {31'd0, stallD}, 32'd0);
`endif
    repeat (3) cycle(next_d(bub), 1'b0, 1'b0);

    // x0 destinations: never a hazard, never forwarded.
    i_a = '0; i_a.rw = 1'b1; i_a.ld = 1'b1; i_a.rd = 5'd0;
    i_c = '0; i_c.rs1 = 5'd0; i_c.rs2 = 5'd0;
    cycle(i_a, 1'b0, 1'b0);
    cycle(i_a, 1'b0, 1'b0);
    cycle(i_c, 1'b0, 1'b0);
    #2 check("x0_no_stall", {31'd0, stallD}, 32'd0);
    cycle(next_d(bub), 1'b0, 1'b0);
    #2 check("x0_fwd_none", {28'd0, fwd_a, fwd_b}, 32'd0);

    // Random traffic with one asynchronous reset mid-stream.
    for (int n = 0; n < 2000; n++) begin
      if (n == 700) begin
        cycle(next_d(rand_instr()), 1'($urandom), 1'b1);
        #1 check("midrst_outputs_zero", all_outs(), 32'd0);
      end else begin
        cycle(next_d(rand_instr()), 1'($urandom), 1'b0);
      end
    end

    repeat (4) cycle(bub, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #1 check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
